button_pulse_debouncer: RTL
===========================

// Module: button_pulse_debouncer
//
// PURPOSE
//   Upstream stage of the display counter. Turns a raw, bouncing push-button
//   (board KEY, active-low) into one clean single-cycle count pulse per press.
//   Also provides a debounced level output.
//   Its pulse output drives the counter's advance input, so each physical press
//   steps the 7-segment digit exactly once.
//
// PARAMETERS
//   STABLE_CYCLES   16   consecutive sampled cycles the input must hold before a
//                        press or release is accepted; legal range 2..65535
//   BTN_ACTIVE_LOW  1    1: btn_in low = pressed; 0: btn_in high = pressed
//   CNT_W (local)        $clog2(STABLE_CYCLES); width of the stability counter
//
// PORTS
//   clk     in   1  single system clock, rising edge
//   rst     in   1  synchronous reset, active-low (rst==0 at posedge resets)
//   btn_in  in   1  raw button, asynchronous to clk, may bounce
//   pulse   out  1  one-cycle high per accepted press (feeds counter advance)
//   level   out  1  debounced state, 1 = pressed (polarity already normalised)
//
// BEHAVIOUR
//   - Sync stage: btn_in passes through 2 flops.
//     Polarity is normalised after the sync stage: s_btn = 1 means pressed.
//   - Reset state (rst==0 at a posedge):
//     - sync flops load the released value;
//     - FSM goes to IDLE; cnt = 0; pulse = 0; level = 0.
//   - Reset overrides everything, in any state, including mid-count.
//   - FSM, 4 states, all registered:
//     IDLE:   s_btn==1 -> ARM_P, cnt=0.
//     ARM_P:  s_btn==0 -> IDLE, cnt=0 (bounce rejected).
//             cnt==STABLE_CYCLES-1 -> HELD.
//             otherwise cnt++.
//     HELD:   s_btn==0 -> ARM_R, cnt=0.
//     ARM_R:  s_btn==1 -> HELD, cnt=0 (bounce rejected).
//             cnt==STABLE_CYCLES-1 -> IDLE.
//             otherwise cnt++.
//   - level = 1 in HELD and ARM_R, 0 in IDLE and ARM_P. Registered.
//   - pulse = 1 only in the cycle right after the ARM_P->HELD edge. Registered.
//     - Never 2 consecutive cycles.
//     - Never on release.
//     - Holding the button indefinitely gives exactly one pulse.
//   - Latency: clean press stable from edge 0 -> pulse high after edge
//     STABLE_CYCLES+3, low again after the next edge.
//     Release has the same latency to level==0.
//   - cnt saturates by construction (it never passes STABLE_CYCLES-1).
//     There is no wrap.
//   - Minimum press-to-press spacing: 2*(STABLE_CYCLES+1) cycles.
//     Shorter glitches are rejected.
//
// STRUCTURE
//   - Package debounce_pkg:
//     - typedef enum logic [1:0] {IDLE, ARM_P, HELD, ARM_R} deb_state_t;
//     - default STABLE_CYCLES constant.
//   - Sub-module sync_2ff (clk, rst, d, q): 2-flop synchroniser, reset value
//     given by a parameter. Reused for the other board switches.
//   - Top level holds the FSM, cnt, and the pulse/level registers.
//     Roughly 150 lines.
//
// TESTING  (STABLE_CYCLES=4, BTN_ACTIVE_LOW=1)
//   1. Reset: rst=0 for 2 edges with btn_in=0
//      -> pulse=0, level=0; state stays IDLE after rst=1.
//   2. Clean press: btn_in 1->0 at edge 0, held
//      -> pulse=1 after edge 7 only; level=1 from edge 7 on.
//   3. Bounce: btn_in=0 for 3 cycles, then back to 1
//      -> pulse stays 0, level stays 0, FSM returns to IDLE.
//   4. Long hold (100 cycles) then clean release
//      -> exactly 1 pulse; level=0 after 7 edges past release.
//   5. Reset mid-ARM_P: rst=0 at edge 5 of a press
//      -> pulse=0, level=0; no pulse until the press is re-qualified
//         (pulse after edge 5+1+7 if btn_in is still low).
//   6. Chain to counter: 3 clean presses
//      -> counter output steps 0->1->2->3, one step per press.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer and its synchroniser.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM_P = 2'd1,
    HELD  = 2'd2,
    ARM_R = 2'd3
  } deb_state_t;

  localparam int DEFAULT_STABLE_CYCLES = 16;

  // Raw pin value that corresponds to "not pressed" for a given polarity.
  function automatic logic released_raw(input logic active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  // Map the raw synchronised pin onto "1 = pressed".
  function automatic logic normalise_btn(input logic raw, input logic active_low);
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; reset loads RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Synchronising flop chain with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_pulse_debouncer.sv
// Debounces a bouncing push-button into a registered level and a single-cycle
// pulse per accepted press, used as the display counter's advance strobe.
module button_pulse_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES  = DEFAULT_STABLE_CYCLES,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse,
  output logic level
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             btn_sync_s;
  logic             s_btn;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  sync_2ff #(
    .RST_VAL (released_raw(BTN_ACTIVE_LOW))
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_sync_s)
  );

  assign s_btn = normalise_btn(btn_sync_s, BTN_ACTIVE_LOW);

  // Next-state, stability counter and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = (state_q == HELD) || (state_q == ARM_R);
    // Entering HELD from ARM_P is the only time level_q is still low in HELD;
    // a rejected release bounce (ARM_R->HELD) therefore never pulses.
    pulse_d = (state_q == HELD) && !level_q;
    case (state_q)
      IDLE: begin
        if (s_btn) begin
          state_d = ARM_P;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      ARM_P: begin
        if (!s_btn) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ARM_P;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s_btn) begin
          state_d = ARM_R;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end
      end
      ARM_R: begin
        if (s_btn) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ARM_R;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule
